bitwise_serial_unit: RTL

Parametrised, sequential bitwise logic unit computing one of eight two-operand bitwise functions (NOT, AND, OR, XOR, NAND, NOR, XNOR, PASS) over a WIDTH-bit word, LANE bits per clock. It sits beside the 16-bit gate library and ALU as the area-reduced logic path, trading latency for a LANE-wide datapath. Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake with Hack-style zero and negative flags.

---
 rtl/bitwise_serial_unit_if.sv | 26 ++
 rtl/bitwise_serial_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/bitwise_serial_unit_if.sv
// Operand and result handshake bundle for bitwise_serial_unit.
// The master drives operands and accepts results; the slave is the unit.
interface bitwise_serial_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic             out_neg;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, out_zero, out_neg
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, out_zero, out_neg
  );
endinterface

// File: rtl/bitwise_serial_unit.sv
// Lane-serial bitwise logic unit: evaluates one of eight two-operand functions
// LANE bits per clock over a WIDTH-bit word, with valid/ready on both sides.
module bitwise_serial_unit #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bitwise_serial_unit_if.slave  bus
);

  localparam int NLANES = WIDTH / LANE;
  localparam int CW     = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(NLANES - 1);

  if ((LANE < 1) || (LANE > WIDTH) || ((WIDTH % LANE) != 0)) begin : g_bad_params
    $error("bitwise_serial_unit: WIDTH must be a non-zero multiple of LANE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic [LANE-1:0] lane_fn(
    input logic [2:0]      f,
    input logic [LANE-1:0] x,
    input logic [LANE-1:0] y
  );
    logic [LANE-1:0] r;
    case (f)
      3'b000:  r = ~x;
      3'b001:  r = x & y;
      3'b010:  r = x | y;
      3'b011:  r = x ^ y;
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x | y);
      3'b110:  r = ~(x ^ y);
      3'b111:  r = x;
      default: r = x;
    endcase
    return r;
  endfunction

  state_t           state_r,     state_nx_s;
  logic [CW-1:0]    cnt_r,       cnt_nx_s;
  logic [WIDTH-1:0] a_hold_r,    a_hold_nx_s;
  logic [WIDTH-1:0] b_hold_r,    b_hold_nx_s;
  logic [2:0]       op_hold_r,   op_hold_nx_s;
  logic [WIDTH-1:0] out_r,       out_nx_s;
  logic             zero_r,      zero_nx_s;
  logic             neg_r,       neg_nx_s;
  logic             out_valid_r, out_valid_nx_s;
  logic             in_ready_r,  in_ready_nx_s;
  logic [LANE-1:0]  lane_res_s;
  logic [WIDTH-1:0] word_s;
  int               idx_s;

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    a_hold_nx_s    = a_hold_r;
    b_hold_nx_s    = b_hold_r;
    op_hold_nx_s   = op_hold_r;
    out_nx_s       = out_r;
    zero_nx_s      = zero_r;
    neg_nx_s       = neg_r;
    out_valid_nx_s = out_valid_r;
    in_ready_nx_s  = in_ready_r;

    // The result is assembled in place in the output register, one lane per cycle.
    idx_s      = int'(cnt_r) * LANE;
    lane_res_s = lane_fn(op_hold_r, a_hold_r[idx_s +: LANE], b_hold_r[idx_s +: LANE]);
    word_s     = out_r;
    word_s[idx_s +: LANE] = lane_res_s;

    case (state_r)
      S_IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          a_hold_nx_s   = bus.a;
          b_hold_nx_s   = bus.b;
          op_hold_nx_s  = bus.op;
          cnt_nx_s      = {CW{1'b0}};
          in_ready_nx_s = 1'b0;
          state_nx_s    = S_RUN;
        end else begin
          in_ready_nx_s = 1'b1;
        end
      end
      S_RUN: begin
        out_nx_s = word_s;
        if (cnt_r == LAST_LANE) begin
          zero_nx_s      = (word_s == {WIDTH{1'b0}});
          neg_nx_s       = word_s[WIDTH-1];
          out_valid_nx_s = 1'b1;
          state_nx_s     = S_DONE;
        end else begin
          cnt_nx_s = cnt_r + CW'(1'b1);
        end
      end
      S_DONE: begin
        if (out_valid_r && bus.out_ready) begin
          out_valid_nx_s = 1'b0;
          in_ready_nx_s  = 1'b1;
          state_nx_s     = S_IDLE;
        end else begin
          out_valid_nx_s = out_valid_r;
        end
      end
      default: begin
        out_valid_nx_s = 1'b0;
        in_ready_nx_s  = 1'b0;
        state_nx_s     = S_IDLE;
      end
    endcase
  end

  // State, holding and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CW{1'b0}};
      a_hold_r    <= {WIDTH{1'b0}};
      b_hold_r    <= {WIDTH{1'b0}};
      op_hold_r   <= 3'b000;
      out_r       <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      a_hold_r    <= a_hold_nx_s;
      b_hold_r    <= b_hold_nx_s;
      op_hold_r   <= op_hold_nx_s;
      out_r       <= out_nx_s;
      zero_r      <= zero_nx_s;
      neg_r       <= neg_nx_s;
      out_valid_r <= out_valid_nx_s;
      in_ready_r  <= in_ready_nx_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.out_zero  = zero_r;
  assign bus.out_neg   = neg_r;

endmodule
